// File: rtl/trigger_capture.sv
// trigger_capture
//   Writes ADC samples into a circular buffer every cycle. Once armed, it waits
//   until PRE_SAMPLES of history have been written, then waits for a trigger.
//   It freezes a window of RECORD_LEN samples, PRE_SAMPLES of them before the
//   trigger sample, and streams that window out oldest-first over valid/ready.
//
// Ports
//   clk        sample clock; ADC_IN is valid every cycle
//   reset      synchronous, active-high; abandons any record in progress
//   ADC_IN     ADC sample
//   trigger    one-cycle trigger pulse (used only while armed)
//   arm        capture request (used only while idle)
//   busy       high from accepted arm until the final output handshake
//   out_data   record sample, oldest first
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   out_last   marks the final sample of a record
module trigger_capture #(
    parameter int DATA_W      = 14,
    parameter int ADDR_W      = 10,
    parameter int PRE_SAMPLES = 128,
    parameter int RECORD_LEN  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ADC_IN,
    input  logic              trigger,
    input  logic              arm,
    output logic              busy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  POST_LEN = CNT_W'(RECORD_LEN - PRE_SAMPLES);
    localparam logic [CNT_W-1:0]  REC_LEN  = CNT_W'(RECORD_LEN);
    localparam logic [CNT_W-1:0]  REC_LAST = CNT_W'(RECORD_LEN - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_SAMPLES);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READOUT} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]  trig_ptr_reg, trig_ptr_next;
    logic [ADDR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   fill_cnt_reg, fill_cnt_next;
    logic [CNT_W-1:0]   post_cnt_reg, post_cnt_next;
    logic [CNT_W-1:0]   out_cnt_reg, out_cnt_next;
    logic               q_valid_reg, q_valid_next;
    logic               q_last_reg, q_last_next;
    logic               out_valid_reg, out_valid_next;
    logic               out_last_reg, out_last_next;
    logic [DATA_W-1:0]  out_data_reg, out_data_next;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  mem_q;

    logic               wr_en, rd_en, out_fire, q_move;
    logic [CNT_W-1:0]   post_cnt_inc;

    // Readout is a two-stage pipe: the RAM read register (mem_q, q_valid) feeds
    // the output register. The RAM register only reloads when it is empty or
    // being drained, so a stall holds both stages and nothing is lost.
    assign wr_en        = (state_reg != READOUT);
    assign out_fire     = out_valid_reg && out_ready;
    assign q_move       = q_valid_reg && (!out_valid_reg || out_ready);
    assign rd_en        = (state_reg == READOUT) && (out_cnt_reg != REC_LEN) &&
                          (!q_valid_reg || q_move);
    assign post_cnt_inc = post_cnt_reg + CNT_W'(1);

    assign busy      = (state_reg != IDLE);
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

    // Sample buffer: writes and reads never happen in the same state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= ADC_IN;
        end
        if (rd_en) begin
            mem_q <= mem[rd_ptr_reg];
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_en ? wr_ptr_reg + ADDR_W'(1) : wr_ptr_reg;
        trig_ptr_next  = trig_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        fill_cnt_next  = fill_cnt_reg;
        post_cnt_next  = post_cnt_reg;
        out_cnt_next   = out_cnt_reg;
        q_valid_next   = q_valid_reg;
        q_last_next    = q_last_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        out_data_next  = out_data_reg;

        case (state_reg)
            IDLE: begin
                // arm wins over a simultaneous trigger; the trigger is dropped
                if (arm) begin
                    state_next    = (PRE_SAMPLES == 0) ? ARMED : FILL;
                    fill_cnt_next = '0;
                end
            end
            FILL: begin
                fill_cnt_next = fill_cnt_reg + CNT_W'(1);
                if (fill_cnt_reg == PRE_LAST) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (trigger) begin
                    // the trigger sample is written at wr_ptr this very cycle
                    trig_ptr_next = wr_ptr_reg;
                    post_cnt_next = CNT_W'(1);
                    if (POST_LEN == CNT_W'(1)) begin
                        state_next   = READOUT;
                        rd_ptr_next  = wr_ptr_reg - PRE_OFS;
                        out_cnt_next = '0;
                    end else begin
                        state_next = POST;
                    end
                end
            end
            POST: begin
                // leave on the cycle that writes the last window sample, so a
                // full-depth record never overwrites its own oldest sample
                post_cnt_next = post_cnt_inc;
                if (post_cnt_inc == POST_LEN) begin
                    state_next   = READOUT;
                    rd_ptr_next  = trig_ptr_reg - PRE_OFS;
                    out_cnt_next = '0;
                end
            end
            READOUT: begin
                if (rd_en) begin
                    rd_ptr_next  = rd_ptr_reg + ADDR_W'(1);
                    out_cnt_next = out_cnt_reg + CNT_W'(1);
                    q_valid_next = 1'b1;
                    q_last_next  = (out_cnt_reg == REC_LAST);
                end else if (q_move) begin
                    q_valid_next = 1'b0;
                end
                if (q_move) begin
                    out_valid_next = 1'b1;
                    out_data_next  = mem_q;
                    out_last_next  = q_last_reg;
                end else if (out_fire) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                end
                if (out_fire && out_last_reg) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    q_valid_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            trig_ptr_reg  <= '0;
            rd_ptr_reg    <= '0;
            fill_cnt_reg  <= '0;
            post_cnt_reg  <= '0;
            out_cnt_reg   <= '0;
            q_valid_reg   <= 1'b0;
            q_last_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            trig_ptr_reg  <= trig_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            fill_cnt_reg  <= fill_cnt_next;
            post_cnt_reg  <= post_cnt_next;
            out_cnt_reg   <= out_cnt_next;
            q_valid_reg   <= q_valid_next;
            q_last_reg    <= q_last_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_data_reg  <= out_data_next;
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Testbench for trigger_capture with ADDR_W=4, PRE_SAMPLES=4, RECORD_LEN=8.
// ADC_IN is a ramp that advances by one every cycle; expected record samples
// are queued when the trigger is driven and compared at each output handshake.
module tb_trigger_capture;

    localparam int DW  = 14;
    localparam int AW  = 4;
    localparam int PRE = 4;
    localparam int RL  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] adc_in = '0;
    logic          trigger = 1'b0;
    logic          arm = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    trigger_capture #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .PRE_SAMPLES(PRE),
        .RECORD_LEN(RL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ADC_IN(adc_in),
        .trigger(trigger),
        .arm(arm),
        .busy(busy),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Reset, then leave the ramp at 0 so the next edge writes 0 at wr_ptr 0.
    task automatic restart();
        reset = 1'b1;
        arm = 1'b0;
        trigger = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        adc_in = '0;
    endtask

    // Runs one capture. arm/trigger fire when the ramp reaches the given values;
    // junk_trig is a trigger the DUT must ignore; stall applies ready 1,0,0,1;
    // extra pulses arm during readout and trigger afterwards, expecting silence.
    task automatic run_capture(input string name, input int arm_at, input int trig_at,
                               input int junk_trig, input bit stall, input bit extra);
        int cyc, got, arm_slot;
        bit done, prev_stall, junk_done, bad, exp_last, prev_last;
        logic [DW-1:0] prev_data, exp_d;
        cyc = 0; got = 0; arm_slot = -1;
        done = 0; prev_stall = 0; junk_done = 0; prev_last = 0; prev_data = '0;
        exp_q.delete();
        while (!done && cyc < 300) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            arm = (adc_in == arm_at) || (extra && out_valid && !junk_done);
            if (extra && out_valid) junk_done = 1;
            trigger = (adc_in == trig_at) || (adc_in == junk_trig);
            if (adc_in == trig_at)
                for (int i = 0; i < RL; i++) exp_q.push_back(DW'(trig_at - PRE + i));
            if (arm_slot >= 0 && cyc == arm_slot + 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_arm: got %b expected 1", name, busy);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL %s hold_while_stalled: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                             name, out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_sample: got %0d expected none", name, out_data);
                    done = 1;
                end else begin
                    exp_d = exp_q.pop_front();
                    exp_last = (exp_q.size() == 0);
                    $display("%s xfer %0d: data=%0d last=%b", name, got, out_data, out_last);
                    if (out_data !== exp_d) begin
                        errors++;
                        $display("FAIL %s data[%0d]: got %0d expected %0d", name, got, out_data, exp_d);
                    end
                    checks++;
                    if (out_last !== exp_last) begin
                        errors++;
                        $display("FAIL %s last[%0d]: got %b expected %b", name, got, out_last, exp_last);
                    end
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy_in_readout: got %b expected 1", name, busy);
                    end
                    if (exp_last) done = 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (adc_in == arm_at) arm_slot = cyc;
            @(posedge clk);
            #1;
            adc_in++;
            cyc++;
        end
        arm = 1'b0;
        trigger = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got %0d samples expected %0d", name, got, RL);
        end
        checks++;
        if (got != RL) begin
            errors++;
            $display("FAIL %s sample_count: got %0d expected %0d", name, got, RL);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after_last: got busy=%b valid=%b last=%b expected 0 0 0",
                     name, busy, out_valid, out_last);
        end
        if (extra) begin
            bad = 0;
            for (int k = 0; k < 30; k++) begin
                trigger = (k == 3);
                if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1;
                @(posedge clk);
                #1;
                adc_in++;
            end
            trigger = 1'b0;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s no_second_record: got activity expected busy=0 valid=0", name);
            end
        end
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        arm = 1'b1;
        trigger = 1'b1;
        adc_in = 14'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        // trigger alone in IDLE does nothing
        arm = 1'b0;
        trigger = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            trigger = (k % 5 == 0);
            if (busy !== 1'b0 || out_valid !== 1'b0) bad = 1;
            @(posedge clk);
            #1;
        end
        trigger = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL idle_trigger_ignored: got activity expected none"); end
    endtask

    task automatic test_basic();
        restart();
        run_capture("basic", 10, 20, -1, 1'b0, 1'b0);
    endtask

    task automatic test_fill_trigger();
        restart();
        run_capture("fill_trigger", 0, 9, 2, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        restart();
        run_capture("stall", 10, 20, -1, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        restart();
        run_capture("wrap", 20, 34, -1, 1'b0, 1'b0);
    endtask

    task automatic test_arm_with_trigger();
        restart();
        run_capture("arm_with_trigger", 10, 20, 10, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int fires, base;
        // reset while in POST
        restart();
        while (adc_in != 22) begin
            arm = (adc_in == 10);
            trigger = (adc_in == 20);
            @(posedge clk);
            #1;
            adc_in++;
        end
        arm = 1'b0;
        trigger = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        adc_in++;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_post: got busy=%b valid=%b last=%b expected 0 0 0",
                     busy, out_valid, out_last);
        end
        base = int'(adc_in);
        run_capture("after_post_reset", base + 1, base + 13, -1, 1'b0, 1'b0);
        // reset after three samples of readout
        restart();
        fires = 0;
        for (int c = 0; c < 200 && fires < 3; c++) begin
            arm = (adc_in == 10);
            trigger = (adc_in == 20);
            if (out_valid && out_ready) fires++;
            if (fires == 3) reset = 1'b1;
            @(posedge clk);
            #1;
            adc_in++;
        end
        reset = 1'b0;
        arm = 1'b0;
        trigger = 1'b0;
        checks++;
        if (fires != 3) begin
            errors++;
            $display("FAIL reset_mid_readout_reach: got %0d handshakes expected 3", fires);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_readout: got busy=%b valid=%b last=%b expected 0 0 0",
                     busy, out_valid, out_last);
        end
        base = int'(adc_in);
        run_capture("after_readout_reset", base + 1, base + 13, -1, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        restart();
        run_capture("ignored_inputs", 10, 20, 22, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_trigger();
        test_stall();
        test_wrap();
        test_arm_with_trigger();
        test_reset_mid();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
